// File: rtl/box_outline_gen.sv
// box_outline_gen: streams the clockwise perimeter pixels of a frame-clamped box under valid/ready.
module box_outline_gen #(
    parameter int          COORD_WIDTH = 5,
    parameter int          FRAME_W     = 32,
    parameter int          FRAME_H     = 32,
    parameter int          HALF_WIDTH  = 3,
    parameter logic [15:0] COLOR       = 16'hF800
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   box_valid_in,
    output logic                   box_ready_out,
    input  logic [COORD_WIDTH-1:0] hcenter_in,
    input  logic [COORD_WIDTH-1:0] vcenter_in,
    input  logic [HALF_WIDTH-1:0]  half_in,
    output logic                   pixel_valid_out,
    input  logic                   pixel_ready_in,
    output logic [COORD_WIDTH-1:0] hcount_out,
    output logic [COORD_WIDTH-1:0] vcount_out,
    output logic [15:0]            pixel_out,
    output logic                   last_out,
    output logic                   done_out
);
    localparam int CW = COORD_WIDTH;
    localparam int SW = COORD_WIDTH + 2;
    localparam logic signed [SW-1:0] HMAX = SW'(FRAME_W - 1);
    localparam logic signed [SW-1:0] VMAX = SW'(FRAME_H - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, SETUP, TOP, RIGHT, BOTTOM, LEFT} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [HALF_WIDTH-1:0] half_q, half_d;
    logic [CW-1:0] l_q, l_d, r_q, r_d, t_q, t_d, b_q, b_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic valid_q, valid_d, done_q, done_d;

    logic signed [SW-1:0] hs, vs, hf, lo_h, hi_h, lo_v, hi_v;
    logic [CW-1:0] l_c, r_c, t_c, b_c;
    logic [CW:0] t_p1;
    logic drop, tall, at_end, xfer, box_ready;

    assign hs   = $signed({2'b00, hc_q});
    assign vs   = $signed({2'b00, vc_q});
    assign hf   = $signed(SW'(half_q));
    assign lo_h = hs - hf;
    assign hi_h = hs + hf;
    assign lo_v = vs - hf;
    assign hi_v = vs + hf;
    assign l_c  = lo_h < 0 ? '0 : lo_h[CW-1:0];
    assign r_c  = hi_h > HMAX ? CW'(FRAME_W - 1) : hi_h[CW-1:0];
    assign t_c  = lo_v < 0 ? '0 : lo_v[CW-1:0];
    assign b_c  = hi_v > VMAX ? CW'(FRAME_H - 1) : hi_v[CW-1:0];
    assign drop = hs > HMAX || vs > VMAX;

    // LEFT segment exists only when at least one row lies strictly between T and B
    assign t_p1 = {1'b0, t_q} + (CW+1)'(1);
    assign tall = {1'b0, b_q} > t_p1;

    assign at_end = (state_q == TOP)    ? (h_q == r_q && b_q == t_q) :
                    (state_q == RIGHT)  ? (v_q == b_q && r_q == l_q) :
                    (state_q == BOTTOM) ? (h_q == l_q && !tall) :
                    (state_q == LEFT)   ? ({1'b0, v_q} == t_p1) : 1'b0;

    assign xfer      = valid_q && pixel_ready_in;
    assign box_ready = state_q == IDLE && !done_q;

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        half_d  = half_q;
        l_d     = l_q;
        r_d     = r_q;
        t_d     = t_q;
        b_d     = b_q;
        h_d     = h_q;
        v_d     = v_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (box_valid_in && box_ready) begin
                    hc_d    = hcenter_in;
                    vc_d    = vcenter_in;
                    half_d  = half_in;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (drop) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    l_d     = l_c;
                    r_d     = r_c;
                    t_d     = t_c;
                    b_d     = b_c;
                    h_d     = l_c;
                    v_d     = t_c;
                    valid_d = 1'b1;
                    state_d = TOP;
                end
            end
            default: begin
                if (xfer && at_end) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    // each corner pixel belongs to the segment that ends there
                    case (state_q)
                        TOP: begin
                            h_d     = h_q != r_q ? h_q + ONE : h_q;
                            v_d     = h_q != r_q ? v_q : v_q + ONE;
                            state_d = h_q != r_q ? TOP : RIGHT;
                        end
                        RIGHT: begin
                            v_d     = v_q != b_q ? v_q + ONE : v_q;
                            h_d     = v_q != b_q ? h_q : h_q - ONE;
                            state_d = v_q != b_q ? RIGHT : BOTTOM;
                        end
                        BOTTOM: begin
                            h_d     = h_q != l_q ? h_q - ONE : h_q;
                            v_d     = h_q != l_q ? v_q : v_q - ONE;
                            state_d = h_q != l_q ? BOTTOM : LEFT;
                        end
                        default: v_d = v_q - ONE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            hc_q    <= '0;
            vc_q    <= '0;
            half_q  <= '0;
            l_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            h_q     <= '0;
            v_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            half_q  <= half_d;
            l_q     <= l_d;
            r_q     <= r_d;
            t_q     <= t_d;
            b_q     <= b_d;
            h_q     <= h_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign box_ready_out   = box_ready;
    assign pixel_valid_out = valid_q;
    assign hcount_out      = h_q;
    assign vcount_out      = v_q;
    assign pixel_out       = valid_q ? COLOR : 16'h0000;
    assign last_out        = valid_q && at_end;
    assign done_out        = done_q;
endmodule

// File: doc/box_outline_gen.md
Name: box_outline_gen

Overview:
Parametrised rectangle-outline generator for the tracking overlay. Accepts one box request at a time: a predicted centre coordinate and a runtime half-size. Streams the coordinates of every perimeter pixel, one per cycle, under a valid/ready handshake, with a constant overlay colour. The box is clamped to the frame, so every emitted coordinate is on-screen. Sits between the position predictor and the overlay frame-buffer writer.

Parameters:
COORD_WIDTH, 5, width of h/v coordinates
FRAME_W, 32, frame width in pixels (legal h: 0..FRAME_W-1)
FRAME_H, 32, frame height in pixels (legal v: 0..FRAME_H-1)
HALF_WIDTH, 3, width of half-size input (max half = 2^HALF_WIDTH-1)
COLOR, 16'hF800, RGB565 colour driven on pixel_out

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
box_valid_in  in  1  box request valid
box_ready_out  out  1  block idle, request accepted this cycle if valid
hcenter_in  in  COORD_WIDTH  box centre, horizontal
vcenter_in  in  COORD_WIDTH  box centre, vertical
half_in  in  HALF_WIDTH  half-size (box spans centre±half)
pixel_valid_out  out  1  output coordinate valid
pixel_ready_in  in  1  downstream accepts coordinate
hcount_out  out  COORD_WIDTH  perimeter pixel h
vcount_out  out  COORD_WIDTH  perimeter pixel v
pixel_out  out  16  colour, always COLOR while valid
last_out  out  1  qualifies final pixel of box (with pixel_valid_out)
done_out  out  1  one-cycle pulse when box finished or dropped

Behaviour:
- Reset (sync, rst_in high at clk edge): state IDLE; box_ready_out=1, pixel_valid_out=0, last_out=0, done_out=0, hcount_out=0, vcount_out=0, pixel_out=0. Reset mid-box abandons it: no further pixels, no done pulse.
- States: IDLE, SETUP, TOP, RIGHT, BOTTOM, LEFT.
- IDLE: box_ready_out=1. On box_valid_in: latch inputs, go SETUP. box_ready_out=0 in all other states.
- SETUP (1 cycle): signed arithmetic with COORD_WIDTH+2 bits. L=max(hc-half,0), R=min(hc+half,FRAME_W-1), T=max(vc-half,0), B=min(vc+half,FRAME_H-1). If hc>=FRAME_W or vc>=FRAME_H: drop the box, pulse done_out, go IDLE. Otherwise load the first pixel (L,T), assert pixel_valid_out, go TOP.
- Latency: request accepted at edge N; first pixel valid at edge N+2.
- Walk order, clockwise, no duplicates:
  - TOP: (L..R, T).
  - RIGHT: (R, T+1..B).
  - BOTTOM: (R-1..L, B).
  - LEFT: (L, B-1..T+1).
  - Empty segments are skipped with no bubble cycle.
- Degenerate boxes:
  - W=R-L+1, H=B-T+1.
  - If H==1: emit TOP only (W pixels).
  - Else if W==1: emit TOP then RIGHT (H pixels).
  - Else: emit 2W+2H-4 pixels.
  - half=0 yields exactly one pixel.
- Handshake:
  - A pixel transfers when pixel_valid_out && pixel_ready_in.
  - While stalled, hcount_out, vcount_out, last_out and pixel_out hold.
  - The next pixel is presented on the cycle after the transfer, giving full throughput at 1 pixel/cycle.
  - pixel_valid_out never drops mid-box except after the final transfer.
- Completion:
  - last_out is high with the final pixel.
  - On its transfer, pixel_valid_out=0, done_out pulses on the next cycle, and the state returns to IDLE.
  - A new request can be accepted in the cycle after the done_out pulse.
- pixel_out=COLOR whenever pixel_valid_out=1; otherwise 0.
- box_valid_in is ignored when not IDLE; requests are never queued.

Test Plan:
- Centre (10,10), half 3, ready held 1 -> 24 pixels on consecutive cycles; first (7,7); 7th (13,7); 13th (13,13); 19th (7,13); 24th (7,8) with last_out=1; done_out one cycle later; no coordinate repeated.
- Centre (1,30), half 3 -> clamped to L=0, R=4, T=27, B=31; 16 pixels; first (0,27); last (0,28); all coordinates in frame.
- Centre (5,5), half 0 -> single pixel (5,5) with last_out=1 at edge N+2 after acceptance; done_out next cycle.
- Centre (10,10), half 3, pixel_ready_in low for 3 cycles while pixel 5 (11,7) is presented -> (11,7) held stable; stream resumes (12,7); total still 24, no skip or duplicate.
- Reset asserted while pixel 10 is presented -> next cycle pixel_valid_out=0, box_ready_out=1, no done_out; a new box (20,20) half 1 then yields 8 pixels starting (19,19).
- FRAME_W=24 build, centre (28,4) -> no pixels; done_out pulses at edge N+2; box_ready_out=1 after.
